// File: rtl/bp_sched_pkg.sv
// Shared types and default parameters for the branch-predictor access scheduler.
package bp_sched_pkg;

  localparam int unsigned DefAddrW     = 4;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefMaxDefer  = 8;

  // Arbitration mode for the coming cycle, derived from registered queue/defer state.
  typedef enum logic [1:0] {
    GrantLk  = 2'd0,
    GrantUpd = 2'd1,
    ForceUpd = 2'd2
  } sched_state_e;

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO holding pending {addr, taken} predictor updates.
// The caller never pushes when full nor pops when empty.
module bp_update_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q, count_d;

  // Occupancy is unchanged on a simultaneous push and pop.
  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // Pointers and count; Depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bp_access_scheduler.sv
// Arbitrates a single-ported branch predictor between fetch lookups and queued
// resolved-branch updates. Lookups have priority, bounded by a defer counter so
// queued updates cannot starve; a full queue also forces updates.
module bp_access_scheduler
  import bp_sched_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned MAX_DEFER  = DefMaxDefer
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lk_valid_i,
  input  logic [ADDR_W-1:0]           lk_addr_i,
  output logic                        lk_ready_o,
  output logic                        pred_valid_o,
  output logic                        pred_taken_o,
  input  logic                        upd_valid_i,
  input  logic [ADDR_W-1:0]           upd_addr_i,
  input  logic                        upd_taken_i,
  output logic                        upd_ready_o,
  output logic                        p_cs_o,
  output logic                        p_enable_o,
  output logic [ADDR_W-1:0]           p_addr_o,
  output logic                        p_result_o,
  input  logic                        p_prediction_i,
  output logic [$clog2(FIFO_DEPTH):0] q_count_o
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DeferW = $clog2(MAX_DEFER + 1);
  localparam logic [CntW-1:0]   FullCount = CntW'(FIFO_DEPTH);
  localparam logic [DeferW-1:0] DeferMax  = DeferW'(MAX_DEFER);

  sched_state_e      state_q, state_d;
  logic [DeferW-1:0] defer_q, defer_d;
  logic              pred_valid_q;

  logic [CntW-1:0]   count, count_d;
  logic [ADDR_W:0]   head;
  logic              q_empty, q_full;
  logic              lk_ready, upd_ready;
  logic              gnt_lk, gnt_upd, push;

  bp_update_fifo #(
    .Width (ADDR_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({upd_addr_i, upd_taken_i}),
    .pop_i   (gnt_upd),
    .rdata_o (head),
    .count_o (count)
  );

  // Readiness comes only from registered state so lk_valid never feeds lk_ready.
  always_comb begin
    q_empty   = (count == '0);
    q_full    = (count == FullCount);
    upd_ready = !rst && !q_full;
    lk_ready  = 1'b0;
    unique case (state_q)
      GrantLk:  lk_ready = !rst;
      GrantUpd: lk_ready = 1'b0;
      ForceUpd: lk_ready = 1'b0;
      default:  lk_ready = 1'b0;
    endcase
  end

  // One predictor access per cycle: lookup if granted, else drain the queue head.
  always_comb begin
    gnt_lk     = lk_valid_i && lk_ready;
    gnt_upd    = !rst && !gnt_lk && !q_empty;
    push       = upd_valid_i && upd_ready;
    p_enable_o = gnt_lk || gnt_upd;
    p_cs_o     = gnt_upd;
    p_addr_o   = '0;
    p_result_o = 1'b0;
    if (gnt_lk) begin
      p_addr_o = lk_addr_i;
    end else if (gnt_upd) begin
      {p_addr_o, p_result_o} = head;
    end
  end

  // Next queue occupancy, defer counter and arbitration mode.
  always_comb begin
    count_d = count;
    if (push && !gnt_upd) begin
      count_d = count + 1'b1;
    end else if (!push && gnt_upd) begin
      count_d = count - 1'b1;
    end

    defer_d = defer_q;
    if (gnt_upd || q_empty) begin
      defer_d = '0;
    end else if (gnt_lk && (defer_q != DeferMax)) begin
      defer_d = defer_q + 1'b1;
    end

    // A saturated defer counter implies a non-empty queue, since any pop clears it.
    state_d = GrantLk;
    if (count_d == FullCount) begin
      state_d = GrantUpd;
    end else if (defer_d == DeferMax) begin
      state_d = ForceUpd;
    end
  end

  // Arbitration state, defer counter and one-cycle lookup result flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= GrantLk;
      defer_q      <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      defer_q      <= defer_d;
      pred_valid_q <= gnt_lk;
    end
  end

  assign lk_ready_o   = lk_ready;
  assign upd_ready_o  = upd_ready;
  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_valid_q && p_prediction_i;
  assign q_count_o    = count;

endmodule

// File: tb/tb_bp_access_scheduler.sv
// Self-checking bench for bp_access_scheduler: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_bp_access_scheduler;

  localparam int unsigned AW = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned MD = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              lk_valid;
  logic [AW-1:0]     lk_addr;
  logic              lk_ready;
  logic              pred_valid, pred_taken;
  logic              upd_valid;
  logic [AW-1:0]     upd_addr;
  logic              upd_taken;
  logic              upd_ready;
  logic              p_cs, p_enable;
  logic [AW-1:0]     p_addr;
  logic              p_result;
  logic              p_prediction = 1'b0;
  logic [$clog2(FD):0] q_count;

  always #5 clk = ~clk;

  bp_access_scheduler #(
    .ADDR_W     (AW),
    .FIFO_DEPTH (FD),
    .MAX_DEFER  (MD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lk_valid_i     (lk_valid),
    .lk_addr_i      (lk_addr),
    .lk_ready_o     (lk_ready),
    .pred_valid_o   (pred_valid),
    .pred_taken_o   (pred_taken),
    .upd_valid_i    (upd_valid),
    .upd_addr_i     (upd_addr),
    .upd_taken_i    (upd_taken),
    .upd_ready_o    (upd_ready),
    .p_cs_o         (p_cs),
    .p_enable_o     (p_enable),
    .p_addr_o       (p_addr),
    .p_result_o     (p_result),
    .p_prediction_i (p_prediction),
    .q_count_o      (q_count)
  );

  // Predictor stand-in: 2-bit saturating counters, registered read.
  logic [1:0] ptab [1<<AW] = '{default: 2'b00};

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  always @(posedge clk) begin
    if (p_enable) begin
      if (p_cs) ptab[p_addr] <= sat(ptab[p_addr], p_result);
      else      p_prediction <= ptab[p_addr][1];
    end
  end

  // Reference model state.
  typedef struct {
    int addr;
    bit taken;
  } upd_t;

  upd_t mq[$];
  int   mdefer;
  bit   mpv, mpt;
  int   mctr [1<<AW];

  typedef struct {
    bit lk_v; int lk_a; bit up_v; int up_a; bit up_t;
    bit lk_rdy; bit up_rdy; bit cs; bit en; int paddr; int q; bit pv; bit pt;
  } vec_t;

  vec_t vecs [13];
  vec_t vz;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  bit obs_lk_ready, obs_upd_ready, obs_cs, obs_pv;
  int obs_q;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mdefer = 0;
    mpv    = 0;
    mpt    = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic cyc(input bit has_v, input vec_t v);
    bit   e_lkr, e_upr, lk_g, up_g, e_res;
    int   e_addr, sz;
    upd_t h;
    @(negedge clk);
    if (rst) model_reset();
    sz     = mq.size();
    e_upr  = !rst && (sz != FD);
    e_lkr  = e_upr && (mdefer < MD);
    lk_g   = lk_valid && e_lkr;
    up_g   = !rst && !lk_g && (sz > 0);
    e_addr = 0;
    e_res  = 0;
    if (lk_g) begin
      e_addr = int'(lk_addr);
    end else if (up_g) begin
      e_addr = mq[0].addr;
      e_res  = mq[0].taken;
    end
    chk("lk_ready",   lk_ready,   e_lkr);
    chk("upd_ready",  upd_ready,  e_upr);
    chk("p_enable",   p_enable,   lk_g || up_g);
    chk("p_cs",       p_cs,       up_g);
    chk("p_addr",     p_addr,     e_addr);
    chk("p_result",   p_result,   e_res);
    chk("q_count",    q_count,    sz);
    chk("pred_valid", pred_valid, mpv);
    chk("pred_taken", pred_taken, mpv && mpt);
    obs_lk_ready  = lk_ready;
    obs_upd_ready = upd_ready;
    obs_cs        = p_cs;
    obs_pv        = pred_valid;
    obs_q         = int'(q_count);
    if (has_v) begin
      chk("vec_lk_ready",   lk_ready,   v.lk_rdy);
      chk("vec_upd_ready",  upd_ready,  v.up_rdy);
      chk("vec_p_cs",       p_cs,       v.cs);
      chk("vec_p_enable",   p_enable,   v.en);
      chk("vec_p_addr",     p_addr,     v.paddr);
      chk("vec_q_count",    q_count,    v.q);
      chk("vec_pred_valid", pred_valid, v.pv);
      chk("vec_pred_taken", pred_taken, v.pt);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      mpv = lk_g;
      if (lk_g) mpt = (mctr[lk_addr] >= 2);
      if (up_g || sz == 0) mdefer = 0;
      else if (lk_g && mdefer < MD) mdefer++;
      if (up_g) begin
        h = mq.pop_front();
        if (h.taken) begin
          if (mctr[h.addr] < 3) mctr[h.addr]++;
        end else if (mctr[h.addr] > 0) begin
          mctr[h.addr]--;
        end
      end
      if (upd_valid && e_upr) mq.push_back('{int'(upd_addr), upd_taken});
    end
    cyc_n++;
    #1;
  endtask

  task automatic idle_inputs();
    lk_valid  = 0;
    lk_addr   = '0;
    upd_valid = 0;
    upd_addr  = '0;
    upd_taken = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle=%0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit lkr_at;
    int cs_seen;
    int lk_pct;

    vz = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    //          lk_v lk_a up_v up_a up_t | lkr upr cs en paddr q pv pt
    vecs[0]  = '{1, 3, 0, 0, 0,  1, 1, 0, 1, 3, 0, 0, 0};  // lookup addr 3
    vecs[1]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1, 0};  // result: not taken
    vecs[2]  = '{0, 0, 1, 5, 1,  1, 1, 0, 0, 0, 0, 0, 0};  // queued, no bypass
    vecs[3]  = '{0, 0, 1, 5, 1,  1, 1, 1, 1, 5, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 5, 1,  1, 1, 1, 1, 5, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0,  1, 1, 1, 1, 5, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 5, 0, 0, 0,  1, 1, 0, 1, 5, 0, 0, 0};  // lookup addr 5
    vecs[8]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1, 1};  // now taken
    vecs[9]  = '{0, 0, 1, 2, 1,  1, 1, 0, 0, 0, 0, 0, 0};  // update addr 2 queued
    vecs[10] = '{1, 2, 0, 0, 0,  1, 1, 0, 1, 2, 1, 0, 0};  // lookup wins
    vecs[11] = '{0, 0, 0, 0, 0,  1, 1, 1, 1, 2, 1, 1, 0};  // pre-update value
    vecs[12] = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < (1 << AW); i++) mctr[i] = 0;
    model_reset();
    idle_inputs();
    rst = 1;
    repeat (3) cyc(0, vz);
    rst = 0;

    // Directed vector table starting on the first edge after reset release.
    for (int i = 0; i < 13; i++) begin
      lk_valid  = vecs[i].lk_v;
      lk_addr   = AW'(vecs[i].lk_a);
      upd_valid = vecs[i].up_v;
      upd_addr  = AW'(vecs[i].up_a);
      upd_taken = vecs[i].up_t;
      cyc(1, vecs[i]);
    end

    // Continuous lookups with one update: forced update after MD deferrals.
    seen      = -1;
    lkr_at    = 1;
    lk_valid  = 1;
    lk_addr   = '0;
    upd_valid = 1;
    upd_addr  = 4'd7;
    upd_taken = 1;
    for (int k = 0; k < 20; k++) begin
      cyc(0, vz);
      upd_valid = 0;
      if (obs_cs && seen < 0) begin
        seen   = k;
        lkr_at = obs_lk_ready;
      end
    end
    chk("defer_force_cycle", seen, 9);
    chk("defer_force_lk_ready", lkr_at, 0);
    idle_inputs();
    repeat (2) cyc(0, vz);

    // Fill the queue under lookup pressure; the fifth update stalls one cycle.
    lk_valid  = 1;
    lk_addr   = 4'd1;
    upd_valid = 1;
    upd_addr  = 4'd4;
    upd_taken = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(0, vz);
      if (k == 4) begin
        chk("full_q_count", obs_q, 4);
        chk("full_upd_ready", obs_upd_ready, 0);
        chk("full_lk_ready", obs_lk_ready, 0);
        chk("full_pop", obs_cs, 1);
      end
      if (k == 5) begin
        chk("stall_release_upd_ready", obs_upd_ready, 1);
        upd_valid = 0;
      end else if (obs_upd_ready) begin
        upd_addr = upd_addr + 1'b1;
      end
    end
    idle_inputs();
    repeat (8) cyc(0, vz);

    // Reset with three queued updates and a lookup in flight.
    lk_valid  = 1;
    lk_addr   = 4'd6;
    upd_valid = 1;
    upd_taken = 1;
    for (int k = 0; k < 3; k++) begin
      upd_addr = AW'(k + 8);
      cyc(0, vz);
    end
    upd_valid = 0;
    cyc(0, vz);
    chk("pre_reset_q_count", obs_q, 3);
    rst      = 1;
    lk_valid = 0;
    cyc(0, vz);
    chk("rst_q_count", obs_q, 0);
    chk("rst_pred_valid", obs_pv, 0);
    rst     = 0;
    cs_seen = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(0, vz);
      cs_seen += int'(obs_cs);
    end
    chk("post_reset_no_cs", cs_seen, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      unique case ((n / 500) % 3)
        0:       lk_pct = 30;
        1:       lk_pct = 70;
        default: lk_pct = 100;
      endcase
      lk_valid  = ($urandom_range(0, 99) < lk_pct);
      lk_addr   = AW'($urandom_range(0, (1 << AW) - 1));
      upd_valid = ($urandom_range(0, 99) < 40);
      upd_addr  = AW'($urandom_range(0, (1 << AW) - 1));
      upd_taken = $urandom_range(0, 1) == 1;
      rst       = ($urandom_range(0, 299) == 0);
      cyc(0, vz);
    end
    rst = 0;
    idle_inputs();
    repeat (8) cyc(0, vz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_access_scheduler.md
BP_ACCESS_SCHEDULER -- requirements
Module: bp_access_scheduler

Interface
REQ-001 Parameter ADDR_W, default 4: predictor table index width.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, >=2): pending-update queue depth.
REQ-003 Parameter MAX_DEFER, default 8: consecutive lookup grants allowed while updates wait.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 lk_valid  input  1  fetch lookup request.
REQ-007 lk_addr  input  ADDR_W  lookup index.
REQ-008 lk_ready  output  1  lookup accepted this cycle when lk_valid && lk_ready.
REQ-009 pred_valid  output  1  prediction result valid, one cycle.
REQ-010 pred_taken  output  1  predicted direction; meaningful only while pred_valid.
REQ-011 upd_valid  input  1  resolved-branch update request.
REQ-012 upd_addr  input  ADDR_W  update index.
REQ-013 upd_taken  input  1  resolved outcome, 1 = taken.
REQ-014 upd_ready  output  1  update accepted into queue when upd_valid && upd_ready.
REQ-015 p_cs, p_enable  output  1 each  predictor chip-select and enable.
REQ-016 p_addr  output  ADDR_W  predictor index.
REQ-017 p_result  output  1  outcome driven to predictor.
REQ-018 p_prediction  input  1  registered prediction returned by predictor.
REQ-019 q_count  output  $clog2(FIFO_DEPTH)+1  pending updates.

Function
REQ-020 At most one predictor access per cycle; p_addr, p_result, p_cs and p_enable are combinational from the current grant.
REQ-021 Lookup grant: p_enable=1, p_cs=0, p_addr=lk_addr; counters unchanged.
REQ-022 Update grant: p_enable=1, p_cs=1, p_addr and p_result from the queue head; head popped that cycle.
REQ-023 Idle cycle: p_enable=0, p_cs=0, p_addr and p_result = 0.
REQ-024 Lookup latency is exactly 1: pred_valid=1 the cycle after an accepted lookup, with pred_taken = p_prediction in that cycle.
REQ-025 Updates always pass through the queue; the earliest predictor write is the cycle after acceptance; no bypass.
REQ-026 upd_ready = (q_count != FIFO_DEPTH), registered-state only; a pop on a full queue does not raise upd_ready in the same cycle.
REQ-027 Simultaneous push and pop on a non-full queue leaves q_count unchanged; write and read pointers wrap modulo FIFO_DEPTH.
REQ-028 State machine, states GRANT_LK, GRANT_UPD and FORCE_UPD, evaluated each cycle.
REQ-029 Default priority is lookup; a pending lookup is granted when the queue is not full and the defer counter is below MAX_DEFER.
REQ-030 Defer counter increments on each lookup grant while q_count>0, clears on any update grant or when q_count=0, and saturates at MAX_DEFER.
REQ-031 Defer counter = MAX_DEFER -> FORCE_UPD: one update is granted and lk_ready=0 that cycle.
REQ-032 Queue full -> lk_ready=0; updates are granted until the queue is no longer full.
REQ-033 No lookup and q_count>0 -> update granted.
REQ-034 lk_ready = 1 exactly when a lookup would be granted; no combinational path from lk_valid to lk_ready.
REQ-035 No forwarding: a lookup returns the committed counter state, even when a queued update targets the same index.
REQ-036 Update order to the predictor equals acceptance order.

Reset
REQ-037 rst clears the queue, q_count, defer counter and pred_valid, and sets state to GRANT_LK.
REQ-038 During and after rst, p_cs, p_enable, p_addr, p_result, pred_taken and pred_valid are 0.
REQ-039 rst mid-operation discards queued updates and any in-flight lookup result; no pred_valid follows.
REQ-040 First grant is possible in the first clk edge after rst deasserts.

Structure
REQ-041 Package bp_sched_pkg holds the state enum and defaults for ADDR_W, FIFO_DEPTH and MAX_DEFER.
REQ-042 The queue is sub-module bp_update_fifo (synchronous FIFO, {addr,taken} entries, count output); arbitration stays in the top level.

Verification
REQ-043 Scenario: lookup addr 3 after reset -> pred_valid next cycle with pred_taken=0; p_cs=0 throughout.
REQ-044 Scenario: three taken updates to addr 5, no lookups -> three p_cs pulses in consecutive cycles; a later lookup of addr 5 -> pred_taken=1.
REQ-045 Scenario: continuous lookups plus one update, MAX_DEFER=8 -> update granted on the 9th cycle, lk_ready=0 that cycle.
REQ-046 Scenario: 4 updates with lookups held high -> q_count=4, upd_ready=0, lk_ready=0 until a pop, and the 5th update stalls one cycle.
REQ-047 Scenario: update to addr 2 queued, same-cycle-next lookup of addr 2 -> prediction reflects the pre-update counter.
REQ-048 Scenario: rst asserted with q_count=3 and a lookup in flight -> q_count=0, pred_valid=0, and no p_cs afterward.
